alu_op_sequencer: RTL and testbench

- Registered, handshaked successor to the single-cycle ALU control decoder.
- Decodes the full RV32I ALU operation set, plus RV32M when enabled, into a 5-bit ALU control code.
- Holds multi-cycle (MUL/DIV) operations for a parametrised cycle count before presenting the result.
- Sits between the main decoder and the execute stage, and gives back-pressure to decode through in_ready.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_decode.sv | 65 ++++++
 rtl/alu_op_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: ALU control codes,
// main-decoder alu_op classes and sequencer states.
package alu_pkg;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    AND    = 5'd2,
    OR     = 5'd3,
    XOR    = 5'd4,
    SLT    = 5'd5,
    SLTU   = 5'd6,
    SLL    = 5'd7,
    SRL    = 5'd8,
    SRA    = 5'd9,
    MUL    = 5'd16,
    MULH   = 5'd17,
    MULHSU = 5'd18,
    MULHU  = 5'd19,
    DIV    = 5'd20,
    DIVU   = 5'd21,
    REM    = 5'd22,
    REMU   = 5'd23
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    LDST   = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    RSVD   = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int MAX_CYCLES = 64;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of main-decoder fields into an ALU control code,
// M-extension / illegal flags and the number of cycles the op occupies.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int SUPPORT_M  = 1,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op_5,
  input  logic       i_funct7_5,
  input  logic       i_funct7_0,
  output alu_ctrl_t  o_alu_ctrl,
  output logic       o_is_mdu,
  output logic       o_illegal,
  output logic [6:0] o_cycles
);

  localparam logic [6:0] MUL_N = 7'(MUL_CYCLES);
  localparam logic [6:0] DIV_N = 7'(DIV_CYCLES);

  logic w_m_op;
  assign w_m_op = (SUPPORT_M != 0) && i_op_5 && i_funct7_0;

  always_comb begin
    o_alu_ctrl = ADD;
    o_is_mdu   = 1'b0;
    o_illegal  = 1'b0;
    o_cycles   = 7'd1;
    case (alu_op_t'(i_alu_op))
      LDST: o_alu_ctrl = ADD;
      BRANCH: begin
        case (i_funct3[2:1])
          2'b00:   o_alu_ctrl = SUB;
          2'b10:   o_alu_ctrl = SLT;
          2'b11:   o_alu_ctrl = SLTU;
          default: o_alu_ctrl = ADD;
        endcase
      end
      RTYPE: begin
        if (w_m_op) begin
          // M codes are laid out as 16 + funct3; funct3[2] splits MUL from DIV/REM
          o_alu_ctrl = alu_ctrl_t'({2'b10, i_funct3});
          o_is_mdu   = 1'b1;
          o_cycles   = i_funct3[2] ? DIV_N : MUL_N;
        end else begin
          case (i_funct3)
            3'b000:  o_alu_ctrl = (i_op_5 && i_funct7_5) ? SUB : ADD;
            3'b001:  o_alu_ctrl = SLL;
            3'b010:  o_alu_ctrl = SLT;
            3'b011:  o_alu_ctrl = SLTU;
            3'b100:  o_alu_ctrl = XOR;
            3'b101:  o_alu_ctrl = i_funct7_5 ? SRA : SRL;
            3'b110:  o_alu_ctrl = OR;
            default: o_alu_ctrl = AND;
          endcase
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU control sequencer: decodes on accept, holds
// MUL/DIV ops for their cycle count, and back-pressures decode via in_ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SUPPORT_M  = 1,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_ctrl,
  output logic       is_mdu,
  output logic       illegal,
  output logic       busy
);

  alu_ctrl_t  w_dec_ctrl;
  logic       w_dec_mdu;
  logic       w_dec_illegal;
  logic [6:0] w_dec_cycles;
  logic       w_accept;

  seq_state_t       r_state;
  alu_ctrl_t        r_alu_ctrl;
  logic             r_is_mdu;
  logic             r_illegal;
  logic             r_out_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  alu_op_decode #(
    .SUPPORT_M (SUPPORT_M),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_decode (
    .i_alu_op  (alu_op),
    .i_funct3  (funct3),
    .i_op_5    (op_5),
    .i_funct7_5(funct7_5),
    .i_funct7_0(funct7_0),
    .o_alu_ctrl(w_dec_ctrl),
    .o_is_mdu  (w_dec_mdu),
    .o_illegal (w_dec_illegal),
    .o_cycles  (w_dec_cycles)
  );

  // Flush masks in_ready so a simultaneous input is never taken
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = ~flush;
      DONE:    in_ready = out_ready & ~flush;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_alu_ctrl  <= ADD;
      r_is_mdu    <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_alu_ctrl <= w_dec_ctrl;
            r_is_mdu   <= w_dec_mdu;
            r_illegal  <= w_dec_illegal;
            if (w_dec_cycles > 7'd1) begin
              // N-2 so the DONE transition lands exactly N cycles after accept
              r_state     <= EXEC;
              r_cnt       <= CNT_W'(w_dec_cycles - 7'd2);
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end else if (r_state == DONE && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_alu_ctrl;
  assign is_mdu    = r_is_mdu;
  assign illegal   = r_illegal;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: main instance with M support
// (MUL 20, DIV 33 cycles) and a second instance with M decoding disabled.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic       op_5, funct7_5, funct7_0;

  logic       in_ready, out_valid, is_mdu, illegal, busy;
  logic [4:0] alu_ctrl;
  logic       in_ready_b, out_valid_b, is_mdu_b, illegal_b, busy_b;
  logic [4:0] alu_ctrl_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SUPPORT_M(1), .MUL_CYCLES(20), .DIV_CYCLES(33)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .op_5(op_5), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .is_mdu(is_mdu), .illegal(illegal), .busy(busy)
  );

  alu_op_sequencer #(.SUPPORT_M(0), .MUL_CYCLES(3), .DIV_CYCLES(33)) dut_nom (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .alu_op(alu_op), .funct3(funct3), .op_5(op_5), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .out_valid(out_valid_b), .out_ready(out_ready), .alu_ctrl(alu_ctrl_b),
    .is_mdu(is_mdu_b), .illegal(illegal_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3,
                       input logic o5, input logic f75, input logic f70);
    in_valid = v;
    alu_op   = a;
    funct3   = f3;
    op_5     = o5;
    funct7_5 = f75;
    funct7_0 = f70;
    if (v) $display("[TB] t=%0t issue alu_op=%0d funct3=%0d op5=%0d f7_5=%0d f7_0=%0d",
                    $time, a, f3, o5, f75, f70);
    #1;
  endtask

  logic [2:0] s_f3  [4] = '{3'd1, 3'd5, 3'd3, 3'd7};
  logic       s_f75 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [4:0] s_exp [4] = '{5'd7, 5'd9, 5'd6, 5'd2};
  logic [2:0] b_f3  [4] = '{3'd7, 3'd5, 3'd1, 3'd4};
  logic [4:0] b_exp [4] = '{5'd6, 5'd5, 5'd1, 5'd5};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_is_mdu", is_mdu, 0);
    check("rst_illegal", illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // sub then addi, back-to-back
    drive(1'b1, 2'b10, 3'd0, 1'b1, 1'b1, 1'b0);
    check("sub_in_ready", in_ready, 1);
    tick();
    check("sub_out_valid", out_valid, 1);
    check("sub_ctrl", alu_ctrl, 1);
    drive(1'b1, 2'b10, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check("addi_out_valid", out_valid, 1);
    check("addi_ctrl", alu_ctrl, 0);
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_out_valid", out_valid, 0);

    // Single-cycle stream: one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, s_f3[i], 1'b1, s_f75[i], 1'b0);
      check($sformatf("stream%0d_in_ready", i), in_ready, 1);
      tick();
      check($sformatf("stream%0d_out_valid", i), out_valid, 1);
      check($sformatf("stream%0d_ctrl", i), alu_ctrl, s_exp[i]);
    end
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // DIV: busy for 32 cycles, result on cycle 33
    drive(1'b1, 2'b10, 3'd4, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("nom_div_out_valid", out_valid_b, 1);
    check("nom_div_ctrl", alu_ctrl_b, 4);
    check("nom_div_is_mdu", is_mdu_b, 0);
    for (int k = 1; k <= 32; k++) begin
      check($sformatf("div_c%0d_busy", k), busy, 1);
      check($sformatf("div_c%0d_in_ready", k), in_ready, 0);
      check($sformatf("div_c%0d_out_valid", k), out_valid, 0);
      tick();
    end
    check("div_out_valid", out_valid, 1);
    check("div_ctrl", alu_ctrl, 20);
    check("div_is_mdu", is_mdu, 1);
    check("div_busy", busy, 0);
    tick();
    check("div_drain", out_valid, 0);

    // Back-pressure: OR held while out_ready low, queued SLT taken on release
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 3'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_ctrl", k), alu_ctrl, 3);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    check("bp_next_out_valid", out_valid, 1);
    check("bp_next_ctrl", alu_ctrl, 5);
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush at cycle 10 of a 20-cycle MUL, with a simultaneous input
    drive(1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("mul_busy", busy, 1);
    check("mul_is_mdu", is_mdu, 1);
    for (int k = 1; k < 10; k++) tick();
    check("mul_c10_busy", busy, 1);
    flush = 1'b1;
    drive(1'b1, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready_after", in_ready, 1);
    tick();
    check("flush_not_taken", out_valid, 0);

    // Reset mid-EXEC
    drive(1'b1, 2'b10, 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("mulhu_busy", busy, 1);
    check("mulhu_ctrl", alu_ctrl, 19);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_busy", busy, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_ctrl", alu_ctrl, 0);
    check("rst2_is_mdu", is_mdu, 0);
    check("rst2_illegal", illegal, 0);

    // Reserved alu_op
    drive(1'b1, 2'b11, 3'd5, 1'b1, 1'b1, 1'b0);
    tick();
    check("rsvd_out_valid", out_valid, 1);
    check("rsvd_ctrl", alu_ctrl, 0);
    check("rsvd_illegal", illegal, 1);

    // Branch compares
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, b_f3[i], 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("br%0d_ctrl", i), alu_ctrl, b_exp[i]);
      check($sformatf("br%0d_illegal", i), illegal, 0);
    end

    // Load/store ignores funct fields
    drive(1'b1, 2'b00, 3'd7, 1'b1, 1'b1, 1'b1);
    tick();
    check("ldst_ctrl", alu_ctrl, 0);
    check("ldst_is_mdu", is_mdu, 0);
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("end_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
